rising_edge_trig: RTL and testbench
===================================

RISING_EDGE_TRIG -- requirements
Module: rising_edge_trig

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels, legal range 1..32.
REQ-002 Parameter INIT_LEVEL, default 1'b0: reset value of every channel's history and synchronizer flops.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 in  input  WIDTH: level inputs, may be asynchronous to clk (e.g. baud toggle from PLL domain, bus select strobes).
REQ-006 out  output  WIDTH: per-channel one-cycle pulse on a 0->1 transition of the corresponding in bit.
REQ-007 fall  output  WIDTH: per-channel one-cycle pulse on a 1->0 transition.
REQ-008 level  output  WIDTH: per-channel registered (and, if enabled, synchronized) copy of in.

Function
REQ-009 Each channel SHALL hold a sample flop (cur) and a history flop (prev); every clk edge: cur <= conditioned in bit, prev <= cur.
REQ-010 out[i] SHALL equal cur[i] & ~prev[i]; fall[i] SHALL equal ~cur[i] & prev[i]; level[i] SHALL equal cur[i]; all three are driven only from flops, never combinationally from in.
REQ-011 Latency, sync disabled: in[i] rising before clk edge k gives out[i]=1 from edge k to edge k+1, then 0.
REQ-012 Each detected edge SHALL produce exactly one pulse of exactly one clk cycle, regardless of how long in stays at the new level.
REQ-013 out[i] and fall[i] SHALL never be high in the same cycle.
REQ-014 A transition that reverts before being sampled (pulse shorter than one clk period) MAY be missed; no pulse is required for it.
REQ-015 A toggle every cycle SHALL produce alternating out/fall pulses with no cycle dropped.
REQ-016 Channels SHALL be fully independent; simultaneous edges on several bits SHALL pulse all those bits in the same cycle.

Reset
REQ-017 While rst=1, all cur, prev and synchronizer flops SHALL be forced to INIT_LEVEL; out=0, fall=0, level=INIT_LEVEL.
REQ-018 With INIT_LEVEL=0 and in held high through reset release, out SHALL pulse once in the first cycle the high level reaches cur; with INIT_LEVEL=1, no pulse.
REQ-019 Reset asserted mid-pulse SHALL clear out/fall immediately (asynchronously).

Configuration
REQ-020 Macro RISING_EDGE_TRIG_SYNC_EN defined: each in bit SHALL pass through a 2-flop synchronizer before cur; latency in REQ-011 becomes edge k+2 to k+3.
REQ-021 Macro undefined: in bit SHALL feed cur directly (single sampling flop, no synchronizer); latency per REQ-011.

Structure
REQ-022 Package rising_edge_trig_pkg SHALL hold SYNC_STAGES=2, the default WIDTH, and the WIDTH legal-range limit.
REQ-023 Sub-module sync_2ff (one bit, async reset to parameterized init value) SHALL be instantiated per channel under RISING_EDGE_TRIG_SYNC_EN.

Verification
REQ-024 WIDTH=1, no sync, rst pulse then in 0->1 held 10 cycles -> out=1 for exactly 1 cycle, 1 cycle after the sampling edge; level=1 thereafter.
REQ-025 in 1->0 -> fall=1 for exactly 1 cycle, out stays 0.
REQ-026 WIDTH=4, in=4'b0000 then 4'b0101 -> out=4'b0101 for one cycle; then in=4'b1010 -> out=4'b1010 and fall=4'b0101 in the same cycle.
REQ-027 RISING_EDGE_TRIG_SYNC_EN defined, in rises before edge k -> out high between edges k+2 and k+3 only.
REQ-028 in held 1 through reset release: INIT_LEVEL=0 -> one out pulse; INIT_LEVEL=1 -> none; rst asserted while out=1 -> out=0 without waiting for a clk edge.
REQ-029 in toggled every cycle for 8 cycles -> out and fall alternate every cycle, 4 pulses each, never both high.

Source files
------------

// File: rtl/rising_edge_trig_pkg.sv
// Shared constants for the rising_edge_trig edge detector and its optional input synchronizer.
package rising_edge_trig_pkg;

   localparam int SYNC_STAGES   = 2;
   localparam int DEFAULT_WIDTH = 1;
   localparam int MAX_WIDTH     = 32;

endpackage

// File: rtl/rising_edge_trig_sync_2ff.sv
// One-bit synchronizer of SYNC_STAGES flops, asynchronously reset to INIT_VAL.
module sync_2ff
   import rising_edge_trig_pkg::*;
#(
   parameter logic INIT_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_d;
   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw input one stage deeper each cycle.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   // Synchronizer chain with asynchronous reset to the initial level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{INIT_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rising_edge_trig.sv
// Per-channel rising/falling edge pulse generator with registered level output.
// Define RISING_EDGE_TRIG_SYNC_EN to put a 2-flop synchronizer in front of each channel.
module rising_edge_trig
   import rising_edge_trig_pkg::*;
#(
   parameter int   WIDTH      = DEFAULT_WIDTH,
   parameter logic INIT_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] level
);

   logic [WIDTH-1:0] samp_s;
   logic [WIDTH-1:0] cur_d;
   logic [WIDTH-1:0] cur_q;
   logic [WIDTH-1:0] prev_d;
   logic [WIDTH-1:0] prev_q;

`ifdef RISING_EDGE_TRIG_SYNC_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_sync
      sync_2ff #(
         .INIT_VAL (INIT_LEVEL)
      ) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (in[i]),
         .q   (samp_s[i])
      );
   end
`else
   assign samp_s = in;
`endif

   // Next sample takes the conditioned input; history takes the current sample.
   always_comb begin
      cur_d  = samp_s;
      prev_d = cur_q;
   end

   // Sample and history flops; reset to the same level so no spurious edge is seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q  <= {WIDTH{INIT_LEVEL}};
         prev_q <= {WIDTH{INIT_LEVEL}};
      end else begin
         cur_q  <= cur_d;
         prev_q <= prev_d;
      end
   end

   // Decoded purely from flop outputs, so async reset clears pulses at once.
   assign out   = cur_q & ~prev_q;
   assign fall  = ~cur_q & prev_q;
   assign level = cur_q;

endmodule

// File: tb/tb_rising_edge_trig.sv
// Scoreboard bench for rising_edge_trig: WIDTH=1/INIT=0, WIDTH=4/INIT=0, WIDTH=1/INIT=1, plus sync_2ff.
module tb_rising_edge_trig;

`ifdef RISING_EDGE_TRIG_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic [3:0] o4, f4, l4;
      logic       o1, f1, l1;
      logic       oi, fi, li;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in1, ini, syq;
   logic [3:0] in4;
   logic       out1, fall1, lev1;
   logic       outi, falli, levi;
   logic [3:0] out4, fall4, lev4;

   logic       p1, pi;
   logic [3:0] p4;
   exp_t       sb_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   rising_edge_trig #(.WIDTH(1), .INIT_LEVEL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .in(in1), .out(out1), .fall(fall1), .level(lev1));
   rising_edge_trig #(.WIDTH(4), .INIT_LEVEL(1'b0)) u_dut4 (
      .clk(clk), .rst(rst), .in(in4), .out(out4), .fall(fall4), .level(lev4));
   rising_edge_trig #(.WIDTH(1), .INIT_LEVEL(1'b1)) u_duti (
      .clk(clk), .rst(rst), .in(ini), .out(outi), .fall(falli), .level(levi));
   sync_2ff #(.INIT_VAL(1'b0)) u_sync (
      .clk(clk), .rst(rst), .d(in1), .q(syq));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic preload();
      exp_t e;
      e.o4 = 4'b0000; e.f4 = 4'b0000; e.l4 = 4'b0000;
      e.o1 = 1'b0;    e.f1 = 1'b0;    e.l1 = 1'b0;
      e.oi = 1'b0;    e.fi = 1'b0;    e.li = 1'b1;
      sb_q.delete();
      for (int k = 0; k < LAT; k++) sb_q.push_back(e);
   endtask

   // Called at a negedge; drives one cycle, checks after the next posedge, returns at the next negedge.
   task automatic step(input logic a1, input logic [3:0] a4, input logic ai);
      exp_t e, g;
      logic exp_sy;
      in1 = a1; in4 = a4; ini = ai;
      e.o1 = a1 & ~p1;  e.f1 = ~a1 & p1;  e.l1 = a1;
      e.o4 = a4 & ~p4;  e.f4 = ~a4 & p4;  e.l4 = a4;
      e.oi = ai & ~pi;  e.fi = ~ai & pi;  e.li = ai;
      sb_q.push_back(e);
      exp_sy = p1;
      p1 = a1; p4 = a4; pi = ai;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         g = sb_q.pop_front();
         check_val("out1",  32'(out1),  32'(g.o1));
         check_val("fall1", 32'(fall1), 32'(g.f1));
         check_val("lev1",  32'(lev1),  32'(g.l1));
         check_val("out4",  32'(out4),  32'(g.o4));
         check_val("fall4", 32'(fall4), 32'(g.f4));
         check_val("lev4",  32'(lev4),  32'(g.l4));
         check_val("outi",  32'(outi),  32'(g.oi));
         check_val("falli", 32'(falli), 32'(g.fi));
         check_val("levi",  32'(levi),  32'(g.li));
      end else begin
         n_bad++;
         $display("FAIL sb_empty: got empty scoreboard expected an entry at %0t", $time);
      end
      check_val("excl4", 32'(out4 & fall4), 32'd0);
      check_val("sync_q", 32'(syq), 32'(exp_sy));
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_out4"},  32'(out4),  32'd0);
      check_val({tag, "_fall4"}, 32'(fall4), 32'd0);
      check_val({tag, "_lev4"},  32'(lev4),  32'd0);
      check_val({tag, "_out1"},  32'(out1),  32'd0);
      check_val({tag, "_lev1"},  32'(lev1),  32'd0);
      check_val({tag, "_outi"},  32'(outi),  32'd0);
      check_val({tag, "_levi"},  32'(levi),  32'd1);
      check_val({tag, "_syncq"}, 32'(syq),   32'd0);
   endtask

   // Asserts reset between edges, holds inputs through release; returns at a negedge.
   task automatic reset_dut(input logic a1, input logic [3:0] a4, input logic ai);
      rst = 1'b1;
      in1 = a1; in4 = a4; ini = ai;
      #1;
      check_reset_state("rst_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst_hold");
      rst = 1'b0;
      p1 = 1'b0; p4 = 4'b0000; pi = 1'b1;
      preload();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      in1 = 1'b0; in4 = 4'b0000; ini = 1'b1;
      p1 = 1'b0; p4 = 4'b0000; pi = 1'b1;
      @(negedge clk);

      // In held high through release: INIT 0 channel pulses once, INIT 1 does not.
      reset_dut(1'b1, 4'b0000, 1'b1);
      repeat (LAT + 3) step(1'b1, 4'b0000, 1'b1);

      // Rise held ten cycles, then fall; 4-bit 0101 then 1010.
      repeat (2) step(1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 4'b0101, 1'b1);
      repeat (3) step(1'b0, 4'b1010, 1'b0);

      // Toggle every cycle.
      for (int i = 0; i < 8; i++) begin
         logic v;
         v = ((i % 2) == 0);
         step(v, v ? 4'b1111 : 4'b0000, v);
      end

      // Reset asserted while pulses are high.
      step(1'b1, 4'b1111, 1'b1);
      repeat (LAT) step(1'b1, 4'b1111, 1'b1);
      reset_dut(1'b1, 4'b1111, 1'b1);

      for (int i = 0; i < 30; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      repeat (LAT + 1) step(1'b0, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
